// File: rtl/cmd_sender_if.sv
// UART byte-level link between the command sender and the TX/RX UART.
// master = command sender, slave = UART.
interface cmd_sender_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;

  modport master (
    output trmt, tx_data, clr_rx_rdy,
    input  tx_done, rx_rdy, rx_data
  );

  modport slave (
    input  trmt, tx_data, clr_rx_rdy,
    output tx_done, rx_rdy, rx_data
  );
endinterface

// File: rtl/cmd_sender.sv
// Host-side command sender: sends a 16-bit command as two UART bytes
// (high first), then waits for a one-byte response or a timeout.
module cmd_sender #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  cmd,
  input  logic         snd_cmd,
  output logic         busy,
  output logic         cmd_snt,
  output logic [7:0]   resp,
  output logic         resp_rdy,
  output logic         resp_timeout,
  cmd_sender_if.master uart
);

  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, TX_HI, WAIT_HI, TX_LO, WAIT_LO, WAIT_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [7:0]    txd_q, txd_d;
  logic [7:0]    resp_q, resp_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          snt_q, snt_d;
  logic          rrdy_q, rrdy_d;
  logic          tout_q, tout_d;
  logic          clr_q, clr_d;
  logic          rx_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      txd_q   <= '0;
      resp_q  <= '0;
      tmr_q   <= '0;
      snt_q   <= 1'b0;
      rrdy_q  <= 1'b0;
      tout_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      txd_q   <= txd_d;
      resp_q  <= resp_d;
      tmr_q   <= tmr_d;
      snt_q   <= snt_d;
      rrdy_q  <= rrdy_d;
      tout_q  <= tout_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    txd_d   = txd_q;
    resp_d  = resp_q;
    tmr_d   = tmr_q;
    snt_d   = snt_q;
    rrdy_d  = rrdy_q;
    tout_d  = tout_q;
    clr_d   = 1'b0;
    // A byte already being consumed must not be seen twice.
    rx_ok   = uart.rx_rdy && !clr_q;
    unique case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          buf_d   = cmd;
          txd_d   = cmd[15:8];
          snt_d   = 1'b0;
          rrdy_d  = 1'b0;
          tout_d  = 1'b0;
          state_d = TX_HI;
        end
      end
      TX_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (uart.tx_done) begin
          txd_d   = buf_q[7:0];
          state_d = TX_LO;
        end
      end
      TX_LO: state_d = WAIT_LO;
      WAIT_LO: begin
        if (uart.tx_done) begin
          snt_d   = 1'b1;
          tmr_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (tmr_q != '1) tmr_d = tmr_q + TW'(1);
        if (rx_ok) begin
          resp_d  = uart.rx_data;
          rrdy_d  = 1'b1;
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && tmr_q == TLAST) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rx_ok && state_q != WAIT_RESP) clr_d = 1'b1;
  end

  assign busy            = (state_q != IDLE);
  assign cmd_snt         = snt_q;
  assign resp            = resp_q;
  assign resp_rdy        = rrdy_q;
  assign resp_timeout    = tout_q;
  assign uart.trmt       = (state_q == TX_HI) || (state_q == TX_LO);
  assign uart.tx_data    = txd_q;
  assign uart.clr_rx_rdy = clr_q;

endmodule

// File: tb/tb_cmd_sender.sv
// Bench for cmd_sender: UART model on the link, byte and response
// scoreboards, directed command scenarios.
module tb_cmd_sender;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        busy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        resp_timeout;

  cmd_sender_if u();

  cmd_sender #(.TIMEOUT_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .busy         (busy),
    .cmd_snt      (cmd_snt),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .resp_timeout (resp_timeout),
    .uart         (u)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         clr_cnt = 0;
  int         txcnt = 0;
  logic [7:0] held = '0;
  logic [7:0] exp_q[$];
  logic [7:0] rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model: checks each transmitted byte, returns tx_done after 10.
  initial begin
    u.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      u.tx_done = 1'b0;
      if (u.clr_rx_rdy) clr_cnt++;
      if (rst) begin
        txcnt = 0;
      end else begin
        if (txcnt > 0) begin
          chk("tx_hold", u.tx_data, held);
          txcnt--;
          if (txcnt == 0) u.tx_done = 1'b1;
        end
        if (u.trmt) begin
          if (exp_q.size() == 0) chk("trmt_extra", 1, 0);
          else chk("tx_byte", u.tx_data, exp_q.pop_front());
          held  = u.tx_data;
          txcnt = 10;
        end
      end
    end
  end

  task automatic send(input logic [15:0] c);
    cmd     = c;
    snd_cmd = 1'b1;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    @(negedge clk);
    snd_cmd = 1'b0;
    chk("latency_trmt", u.trmt, 1);
    chk("busy_on", busy, 1);
    chk("snt_clr", cmd_snt, 0);
    chk("rrdy_clr", resp_rdy, 0);
    chk("tout_clr", resp_timeout, 0);
  endtask

  task automatic wait_snt();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_snt) break;
    end
    chk("snt_seen", cmd_snt, 1);
    chk("snt_busy", busy, 1);
  endtask

  task automatic respond(input logic [7:0] d, input int dly);
    int c0;
    repeat (dly) @(negedge clk);
    c0 = clr_cnt;
    rx_data_drive(d, 1'b1);
    rsp_q.push_back(d);
    @(negedge clk);
    rx_data_drive(d, 1'b0);
    chk("clr_pulse", u.clr_rx_rdy, 1);
    @(negedge clk);
    chk("resp", resp, rsp_q.pop_front());
    chk("resp_rdy", resp_rdy, 1);
    chk("resp_tout", resp_timeout, 0);
    chk("busy_off", busy, 0);
    chk("clr_count", clr_cnt - c0, 1);
  endtask

  task automatic rx_data_drive(input logic [7:0] d, input logic v);
    u.rx_data = d;
    u.rx_rdy  = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst       = 1'b1;
    cmd       = '0;
    snd_cmd   = 1'b0;
    u.rx_rdy  = 1'b0;
    u.rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_trmt", u.trmt, 0);
    chk("rst_txd", u.tx_data, 0);
    chk("rst_resp", resp, 0);
    chk("rst_flags", {cmd_snt, resp_rdy, resp_timeout, u.clr_rx_rdy}, 0);

    // Stale byte in IDLE is discarded.
    c0 = clr_cnt;
    rx_data_drive(8'h77, 1'b1);
    @(negedge clk);
    rx_data_drive(8'h77, 1'b0);
    chk("stale_clr", u.clr_rx_rdy, 1);
    repeat (2) @(negedge clk);
    chk("stale_count", clr_cnt - c0, 1);
    chk("stale_rrdy", resp_rdy, 0);
    chk("stale_resp", resp, 0);

    // Normal command.
    send(16'hA5C3);
    wait_snt();
    respond(8'hA5, 10);

    // snd_cmd while in WAIT_HI is ignored.
    send(16'hBEEF);
    repeat (4) @(negedge clk);
    cmd     = 16'h1234;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    wait_snt();
    respond(8'h3E, 5);

    // Timeout, no response.
    send(16'h5A0F);
    wait_snt();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_timeout) begin
        n = i;
        break;
      end
    end
    chk("tout_cycles", n, 20);
    chk("tout_rrdy", resp_rdy, 0);
    chk("tout_busy", busy, 0);

    // Response and timeout in the same cycle: response wins.
    send(16'h0F5A);
    wait_snt();
    respond(8'hC7, 19);

    // Reset during WAIT_LO, then a fresh command.
    send(16'h3C96);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("lo_sent", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("in_wait_lo", {busy, cmd_snt}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_trmt", u.trmt, 0);
    chk("mid_txd", u.tx_data, 0);
    chk("mid_resp", resp, 0);
    chk("mid_flags", {cmd_snt, resp_rdy, resp_timeout, u.clr_rx_rdy}, 0);
    repeat (15) @(negedge clk);
    chk("mid_no_trmt", exp_q.size(), 0);
    send(16'h5AA5);
    wait_snt();
    respond(8'h99, 3);

    // Back-to-back commands.
    send(16'h0001);
    wait_snt();
    respond(8'h11, 2);
    send(16'hFFFF);
    wait_snt();
    respond(8'h22, 2);

    repeat (5) @(negedge clk);
    chk("tx_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
